// File: rtl/ct_f_spsram_rmw_ctrl.sv
// Front-end for the single-port SRAM wrapper: zero-fills the array after reset,
// serves whole-line reads and turns byte-masked writes into a read-modify-write.
module ct_f_spsram_rmw_ctrl #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 128,
    parameter int BE_WIDTH   = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_WIDTH-1:0]   req_be,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_busy,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_MERGE   = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_LINE = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ONE_LINE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [DATA_WIDTH-1:0] expand_be(input logic [BE_WIDTH-1:0] be);
        logic [DATA_WIDTH-1:0] mask_s;
        mask_s = '0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            mask_s[8*i +: 8] = {8{be[i]}};
        end
        return mask_s;
    endfunction

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   init_cnt_r;
    logic                    rsp_vld_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic [ADDR_WIDTH-1:0]   mrg_addr_r;
    logic [DATA_WIDTH-1:0]   mrg_wdata_r;
    logic [DATA_WIDTH-1:0]   mrg_mask_r;

    logic                    req_rdy_s;
    logic                    xfer_s;
    logic                    be_full_s;
    logic                    be_none_s;
    logic                    partial_s;
    logic [ADDR_WIDTH-1:0]   sram_a_s;
    logic                    sram_cen_s;
    logic                    sram_gwen_s;
    logic [DATA_WIDTH-1:0]   sram_wen_s;
    logic [DATA_WIDTH-1:0]   sram_d_s;

    assign be_full_s = &req_be;
    assign be_none_s = ~|req_be;
    assign partial_s = req_wr && !be_full_s && !be_none_s;
    assign xfer_s    = req_vld && req_rdy_s;

    // Accept only in IDLE, and only once any held response is gone or leaving.
    always_comb begin
        req_rdy_s = 1'b0;
        if (!RST && (state_r == ST_IDLE)) begin
            req_rdy_s = !rsp_vld_r || rsp_rdy;
        end else begin
            req_rdy_s = 1'b0;
        end
    end

    // SRAM port drive; IDLE issues straight from the accepted request.
    always_comb begin
        sram_a_s    = req_addr;
        sram_cen_s  = 1'b1;
        sram_gwen_s = 1'b1;
        sram_wen_s  = '1;
        sram_d_s    = '0;
        if (RST) begin
            sram_cen_s = 1'b1;
        end else begin
            case (state_r)
                ST_INIT: begin
                    sram_a_s    = init_cnt_r;
                    sram_cen_s  = 1'b0;
                    sram_gwen_s = 1'b0;
                    sram_wen_s  = '0;
                end
                ST_IDLE: begin
                    if (xfer_s) begin
                        if (!req_wr) begin
                            sram_cen_s = 1'b0;
                        end else if (be_full_s) begin
                            sram_cen_s  = 1'b0;
                            sram_gwen_s = 1'b0;
                            sram_wen_s  = '0;
                            sram_d_s    = req_wdata;
                        end else if (be_none_s) begin
                            sram_cen_s = 1'b1;
                        end else begin
                            // partial write: fetch the old line first
                            sram_cen_s = 1'b0;
                        end
                    end else begin
                        sram_cen_s = 1'b1;
                    end
                end
                ST_MERGE: begin
                    sram_a_s    = mrg_addr_r;
                    sram_cen_s  = 1'b0;
                    sram_gwen_s = 1'b0;
                    sram_wen_s  = '0;
                    sram_d_s    = (sram_q & ~mrg_mask_r) | (mrg_wdata_r & mrg_mask_r);
                end
                ST_RD_WAIT: begin
                    sram_cen_s = 1'b1;
                end
                default: begin
                    sram_cen_s = 1'b1;
                end
            endcase
        end
    end

    // Control FSM, init counter, merge latches and response register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= '0;
            rsp_vld_r   <= 1'b0;
            rsp_rdata_r <= '0;
            mrg_addr_r  <= '0;
            mrg_wdata_r <= '0;
            mrg_mask_r  <= '0;
        end else begin
            if (rsp_vld_r && rsp_rdy) begin
                rsp_vld_r <= 1'b0;
            end
            case (state_r)
                ST_INIT: begin
                    init_cnt_r <= init_cnt_r + ONE_LINE;
                    if (init_cnt_r == LAST_LINE) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (xfer_s) begin
                        if (!req_wr) begin
                            state_r <= ST_RD_WAIT;
                        end else if (partial_s) begin
                            mrg_addr_r  <= req_addr;
                            mrg_wdata_r <= req_wdata;
                            mrg_mask_r  <= expand_be(req_be);
                            state_r     <= ST_MERGE;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    rsp_rdata_r <= sram_q;
                    rsp_vld_r   <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                ST_MERGE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

    assign req_rdy   = req_rdy_s;
    assign rsp_vld   = rsp_vld_r;
    assign rsp_rdata = rsp_rdata_r;
    assign init_busy = RST || (state_r == ST_INIT);
    assign sram_a    = sram_a_s;
    assign sram_cen  = sram_cen_s;
    assign sram_gwen = sram_gwen_s;
    assign sram_wen  = sram_wen_s;
    assign sram_d    = sram_d_s;

endmodule

// File: tb/tb_ct_f_spsram_rmw_ctrl.sv
// Bench for ct_f_spsram_rmw_ctrl: directed vector table, hand sequences for stall
// and reset-in-merge, then random traffic against a byte-level memory model.
module tb_ct_f_spsram_rmw_ctrl;
    localparam int AW    = 14;
    localparam int DW    = 128;
    localparam int BW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          CLK, RST;
    logic          req_vld, req_rdy, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rsp_vld, rsp_rdy;
    logic [DW-1:0] rsp_rdata;
    logic          init_busy;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d, sram_q;

    int total;
    int bad;
    logic fill;

    logic [DW-1:0] sram_mem [0:DEPTH-1];
    logic [DW-1:0] ref_mem  [0:DEPTH-1];

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl [12];

    ct_f_spsram_rmw_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
        .CLK(CLK), .RST(RST),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
        .init_busy(init_busy),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Wrapper model: whole-line write, registered read; fill seeds garbage.
    always @(posedge CLK) begin
        if (fill) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= {4{32'hDEADBEEF}} ^ DW'(i);
        end else if (!sram_cen) begin
            if (!sram_gwen) sram_mem[sram_a] <= sram_d;
            else            sram_q <= sram_mem[sram_a];
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                                  input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic clear_ref();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic run_init();
        int n;
        int wr_err;
        int rdy_err;
        n = 0; wr_err = 0; rdy_err = 0;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = '0;
        @(negedge CLK);
        while (init_busy === 1'b1 && n < 20000) begin
            if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_a !== n[AW-1:0] ||
                sram_d !== '0 || sram_wen !== '0) wr_err++;
            if (req_rdy !== 1'b0) rdy_err++;
            n++;
            @(negedge CLK);
        end
        req_vld = 1'b0;
        chkw("init_len", DW'(n), DW'(DEPTH));
        chkw("init_writes", DW'(wr_err), '0);
        chkw("init_rdy_low", DW'(rdy_err), '0);
        chk1("idle_rdy", req_rdy, 1'b1);
    endtask

    task automatic do_op(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [BW-1:0] be, input int stall, output logic [DW-1:0] got);
        logic [DW-1:0] old;
        old = ref_mem[addr];
        got = '0;
        @(posedge CLK); #1;
        req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
        rsp_rdy = (stall == 0);
        @(negedge CLK);
        chk1("acc_rdy", req_rdy, 1'b1);
        if (!wr) begin
            chk1("rd_cen", sram_cen, 1'b0);
            chk1("rd_gwen", sram_gwen, 1'b1);
            chkw("rd_a", DW'(sram_a), DW'(addr));
        end else if (be == '1) begin
            chk1("fw_cen", sram_cen, 1'b0);
            chk1("fw_gwen", sram_gwen, 1'b0);
            chkw("fw_wen", sram_wen, '0);
            chkw("fw_d", sram_d, wdata);
            chkw("fw_a", DW'(sram_a), DW'(addr));
        end else if (be == '0) begin
            chk1("nw_cen", sram_cen, 1'b1);
        end else begin
            chk1("pw_rd_cen", sram_cen, 1'b0);
            chk1("pw_rd_gwen", sram_gwen, 1'b1);
            chkw("pw_rd_a", DW'(sram_a), DW'(addr));
        end
        @(posedge CLK); #1;
        req_vld = 1'b0;
        if (wr) ref_mem[addr] = merge_bytes(old, wdata, be);
        if (!wr) begin
            @(negedge CLK);
            chk1("rdw_vld", rsp_vld, 1'b0);
            chk1("rdw_cen", sram_cen, 1'b1);
            @(negedge CLK);
            chk1("rsp_vld", rsp_vld, 1'b1);
            got = rsp_rdata;
            for (int k = 0; k < stall; k++) begin
                @(negedge CLK);
                chk1("stall_vld", rsp_vld, 1'b1);
                chkw("stall_data", rsp_rdata, got);
                chk1("stall_rdy", req_rdy, 1'b0);
            end
            rsp_rdy = 1'b1;
            @(negedge CLK);
            chk1("rsp_clr", rsp_vld, 1'b0);
        end else if (be != '0 && be != '1) begin
            @(negedge CLK);
            chk1("mrg_rdy", req_rdy, 1'b0);
            chk1("mrg_cen", sram_cen, 1'b0);
            chk1("mrg_gwen", sram_gwen, 1'b0);
            chkw("mrg_wen", sram_wen, '0);
            chkw("mrg_a", DW'(sram_a), DW'(addr));
            chkw("mrg_d", sram_d, merge_bytes(old, wdata, be));
        end else begin
            @(negedge CLK);
            chk1("wr_rdy_cont", req_rdy, 1'b1);
            chk1("wr_no_access", sram_cen, 1'b1);
        end
    endtask

    initial begin
        logic [DW-1:0] got;
        logic [AW-1:0] ra;
        logic [BW-1:0] rbe;
        logic [DW-1:0] rwd;
        int kind;

        total = 0; bad = 0;
        RST = 1'b1; fill = 1'b1; rsp_rdy = 1'b1;
        req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        clear_ref();

        tbl[0]  = '{1'b0, 14'h0005, '0, '0, '0};
        tbl[1]  = '{1'b0, 14'h3FFF, '0, '0, '0};
        tbl[2]  = '{1'b1, 14'h0010, {16{8'hA5}}, 16'hFFFF, '0};
        tbl[3]  = '{1'b0, 14'h0010, '0, '0, {16{8'hA5}}};
        tbl[4]  = '{1'b1, 14'h0020, {16{8'hFF}}, 16'hFFFF, '0};
        tbl[5]  = '{1'b1, 14'h0020, '0, 16'h0001, '0};
        tbl[6]  = '{1'b0, 14'h0020, '0, '0, {{15{8'hFF}}, 8'h00}};
        tbl[7]  = '{1'b1, 14'h0003, 128'h1234, 16'hFFFF, '0};
        tbl[8]  = '{1'b1, 14'h0003, {4{32'hDEADBEEF}}, 16'h0000, '0};
        tbl[9]  = '{1'b0, 14'h0003, '0, '0, 128'h1234};
        tbl[10] = '{1'b1, 14'h0030, {16{8'hAB}}, 16'h8000, '0};
        tbl[11] = '{1'b0, 14'h0030, '0, '0, {8'hAB, 120'h0}};

        @(posedge CLK); #1;
        fill = 1'b0;
        req_vld = 1'b1;
        @(negedge CLK);
        chk1("rst_cen", sram_cen, 1'b1);
        chk1("rst_gwen", sram_gwen, 1'b1);
        chkw("rst_wen", sram_wen, '1);
        chk1("rst_rdy", req_rdy, 1'b0);
        chk1("rst_busy", init_busy, 1'b1);
        chk1("rst_rsp_vld", rsp_vld, 1'b0);
        chkw("rst_rsp_rdata", rsp_rdata, '0);
        @(posedge CLK); #1;
        RST = 1'b0;
        run_init();

        for (int i = 0; i < 12; i++) begin
            do_op(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, 0, got);
            if (!tbl[i].wr) chkw($sformatf("tbl_rd%0d", i), got, tbl[i].exp);
        end

        // Held response blocks new requests; release accepts the next one the same cycle.
        @(posedge CLK); #1;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 14'h0010; rsp_rdy = 1'b0;
        @(negedge CLK);
        chk1("st_acc", req_rdy, 1'b1);
        @(posedge CLK); #1;
        req_addr = 14'h0020;
        @(negedge CLK);
        chk1("st_wait_rdy", req_rdy, 1'b0);
        @(posedge CLK); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk1("st_vld", rsp_vld, 1'b1);
            chkw("st_data", rsp_rdata, {16{8'hA5}});
            chk1("st_rdy", req_rdy, 1'b0);
        end
        rsp_rdy = 1'b1;
        #1;
        chk1("st_same_cycle", req_rdy, 1'b1);
        @(posedge CLK); #1;
        req_vld = 1'b0;
        @(negedge CLK);
        chk1("st_clr", rsp_vld, 1'b0);
        @(negedge CLK);
        chk1("st_vld2", rsp_vld, 1'b1);
        chkw("st_data2", rsp_rdata, {{15{8'hFF}}, 8'h00});

        for (int n = 0; n < 250; n++) begin
            ra = 14'h0100 + AW'($urandom_range(0, 15));
            rwd = {$urandom, $urandom, $urandom, $urandom};
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                do_op(1'b0, ra, '0, '0, int'($urandom_range(0, 3)), got);
                chkw("rnd_rd", got, ref_mem[ra]);
            end else if (kind == 1) begin
                do_op(1'b1, ra, rwd, '1, 0, got);
            end else if (kind == 2) begin
                do_op(1'b1, ra, rwd, '0, 0, got);
            end else begin
                rbe = BW'($urandom);
                while (rbe == '0 || rbe == '1) rbe = BW'($urandom);
                do_op(1'b1, ra, rwd, rbe, 0, got);
            end
        end

        // Reset lands in the merge cycle: the write must be lost and init must rerun.
        @(posedge CLK); #1;
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 14'h0010; req_wdata = '0; req_be = 16'h00F0;
        @(negedge CLK);
        chk1("rm_acc", req_rdy, 1'b1);
        @(posedge CLK); #1;
        req_vld = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk1("rm_cen", sram_cen, 1'b1);
        chk1("rm_gwen", sram_gwen, 1'b1);
        chkw("rm_wen", sram_wen, '1);
        chk1("rm_rsp_vld", rsp_vld, 1'b0);
        chkw("rm_rsp_rdata", rsp_rdata, '0);
        chk1("rm_busy", init_busy, 1'b1);
        chk1("rm_rdy", req_rdy, 1'b0);
        @(posedge CLK); #1;
        chkw("rm_no_write", sram_mem[14'h0010], {16{8'hA5}});
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        clear_ref();
        run_init();
        do_op(1'b0, 14'h0010, '0, '0, 0, got);
        chkw("rm_line_zero", got, '0);
        do_op(1'b0, 14'h0100, '0, '0, 1, got);
        chkw("rm_rnd_zero", got, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
